// File: rtl/ex_stage_if.sv
// EX stage port bundle: ID->EX bus and allowin upstream, EX->MEM bus downstream.
interface ex_stage_if;
  logic [173:0] ID_to_EX_bus;
  logic         EX_allowin;
  logic [137:0] EX_to_MEM_bus;

  modport master (
    output ID_to_EX_bus,
    input  EX_allowin,
    input  EX_to_MEM_bus
  );

  modport slave (
    input  ID_to_EX_bus,
    output EX_allowin,
    output EX_to_MEM_bus
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus optional 32-iteration restoring divider.
// Divider (ops 13-15) is built only when EX_DIV_EN is defined.
module ex_stage (
  input  logic clk,
  input  logic rst,
  ex_stage_if.slave bus_if
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [3:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        ld_w;
    logic        mem_we;
    logic        res_mem;
    logic        gr_we;
    logic [31:0] rkd;
    logic [4:0]  waddr;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ld_w;
    logic        mem_we;
    logic        res_mem;
    logic        gr_we;
    logic [31:0] rkd;
    logic [4:0]  waddr;
    logic [31:0] result;
  } ex_mem_t;

  id_ex_t      id;
  ex_mem_t     out_d;
  logic [31:0] alu_res;
  logic [31:0] res;
  logic        allowin;
  logic        ld_v;

  assign id = bus_if.ID_to_EX_bus;

  always_comb begin
    alu_res = '0;
    case (id.alu_op)
      4'd0:  alu_res = id.src1 + id.src2;
      4'd1:  alu_res = id.src1 - id.src2;
      4'd2:  alu_res = {31'b0, $signed(id.src1) < $signed(id.src2)};
      4'd3:  alu_res = {31'b0, id.src1 < id.src2};
      4'd4:  alu_res = id.src1 & id.src2;
      4'd5:  alu_res = id.src1 | id.src2;
      4'd6:  alu_res = id.src1 ^ id.src2;
      4'd7:  alu_res = ~(id.src1 | id.src2);
      4'd8:  alu_res = id.src1 << id.src2[4:0];
      4'd9:  alu_res = id.src1 >> id.src2[4:0];
      4'd10: alu_res = $signed(id.src1) >>> id.src2[4:0];
      4'd11: alu_res = id.src2;
      4'd12: alu_res = id.src1 * id.src2;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_e;

  st_e         st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        is_div;
  logic        sgn;
  logic [32:0] trial;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] div_res;

  assign is_div = id.valid && (id.alu_op >= 4'd13);
  assign sgn    = id.alu_op != 4'd15;
  // quo_q doubles as the dividend shift register
  assign trial  = {rem_q, quo_q[31]} - {1'b0, dvs_q};

  always_comb begin
    q_fix = (sgn && (s1_q ^ s2_q)) ? -quo_q : quo_q;
    r_fix = (sgn && s1_q) ? -rem_q : rem_q;
    if (dvs_q == '0) begin
      q_fix = '1;
      r_fix = id.src1;
    end
    div_res = (id.alu_op == 4'd14) ? r_fix : q_fix;
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    allowin = 1'b1;
    res     = alu_res;
    case (st_q)
      IDLE: begin
        if (is_div) begin
          allowin = 1'b0;
          st_d    = BUSY;
          cnt_d   = '0;
          s1_d    = sgn & id.src1[31];
          s2_d    = sgn & id.src2[31];
          quo_d   = s1_d ? -id.src1 : id.src1;
          dvs_d   = s2_d ? -id.src2 : id.src2;
          rem_d   = '0;
        end
      end
      BUSY: begin
        allowin = 1'b0;
        cnt_d   = cnt_q + 5'd1;
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd31) st_d = DONE;
      end
      DONE: begin
        res  = div_res;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
    end
  end
`else
  assign allowin = 1'b1;
  assign res     = alu_res;
`endif

  assign bus_if.EX_allowin = allowin;
  assign ld_v = id.valid & allowin & ~rst;

  always_comb begin
    out_d = '0;
    if (ld_v) begin
      out_d.valid   = 1'b1;
      out_d.pc      = id.pc;
      out_d.ir      = id.ir;
      out_d.ld_w    = id.ld_w;
      out_d.mem_we  = id.mem_we;
      out_d.res_mem = id.res_mem;
      out_d.gr_we   = id.gr_we;
      out_d.rkd     = id.rkd;
      out_d.waddr   = id.waddr;
      out_d.result  = res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bus_if.EX_to_MEM_bus <= '0;
    else     bus_if.EX_to_MEM_bus <= out_d;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model.
// Divider checks follow EX_DIV_EN, matching the build of the design.
module tb_ex_stage;

`ifdef EX_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] f_pc, f_ir, f_rkd;
  logic [3:0]  f_flags;
  logic [4:0]  f_wa;

  ex_stage_if bus_if ();

  ex_stage dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [137:0] got,
                     input logic [137:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~(a | b);
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: begin r = sa >>> b[4:0]; return r[31:0]; end
      4'd11: return b;
      4'd12: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      default: begin
        if (!DIV) return 32'd0;
        if (b == 0) return (op == 4'd14) ? a : 32'hFFFF_FFFF;
        if (op == 4'd13) r = sa / sb;
        else if (op == 4'd14) r = sa % sb;
        else r = longint'(a) / longint'(b);
        return r[31:0];
      end
    endcase
  endfunction

  task automatic present(input bit v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    f_pc    = $urandom;
    f_ir    = $urandom;
    f_rkd   = $urandom;
    f_flags = 4'($urandom);
    f_wa    = 5'($urandom);
    bus_if.ID_to_EX_bus = {v, f_pc, f_ir, op, a, b, f_flags, f_rkd, f_wa};
  endtask

  function automatic logic [137:0] exp_bus(input logic [31:0] r);
    return {1'b1, f_pc, f_ir, f_flags, f_rkd, f_wa, r};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    present(1'b1, op, a, b);
    r = ref_alu(op, a, b);
    if (DIV && op >= 4'd13) begin
      for (int i = 0; i < 33; i++) begin
        chk({tag, "_stall"}, bus_if.EX_allowin, 0);
        tick();
        chk({tag, "_bubble"}, bus_if.EX_to_MEM_bus[137], 0);
      end
    end
    chk({tag, "_allowin"}, bus_if.EX_allowin, 1);
    tick();
    chk(tag, bus_if.EX_to_MEM_bus, exp_bus(r));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] op;
    present(1'b1, 4'd0, 32'd1, 32'd2);
    tick();
    tick();
    chk("reset_bus", bus_if.EX_to_MEM_bus, '0);
    rst = 1'b0;

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
    run_op("sra", 4'd10, 32'h8000_0000, 32'h21);
    run_op("sltu", 4'd3, 32'd1, 32'hFFFF_FFFF);
    run_op("slt", 4'd2, 32'hFFFF_FFFF, 32'd1);
    run_op("lui", 4'd11, 32'h1234, 32'hABCD_0000);
    run_op("div_w", 4'd13, 32'hFFFF_FFF9, 32'd2);
    run_op("mod_w", 4'd14, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_z", 4'd15, 32'd5, 32'd0);
    run_op("mod_z", 4'd14, 32'd5, 32'd0);
    run_op("div_ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_9_3", 4'd13, 32'd9, 32'd3);

    present(1'b0, 4'd13, 32'd9, 32'd3);
    chk("bubble_allowin", bus_if.EX_allowin, 1);
    tick();
    chk("bubble_bus", bus_if.EX_to_MEM_bus, '0);

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 12));
      run_op("rand_alu", op, pick(), pick());
    end
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(13, 15));
      run_op("rand_div", op, pick(), pick());
    end

    // abort a divide mid-flight with reset
    present(1'b1, 4'd13, 32'd100, 32'd7);
    tick();
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_bus", bus_if.EX_to_MEM_bus, '0);
    rst = 1'b0;
    #1;
    chk("abort_allowin", bus_if.EX_allowin, DIV ? 0 : 1);
    run_op("post_add", 4'd0, 32'd3, 32'd4);
    chk("post_add_res", bus_if.EX_to_MEM_bus[31:0], 32'd7);
    present(1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("no_stale", bus_if.EX_to_MEM_bus[137], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Ports: clk input 1 (the stage clock); rst input 1 (synchronous, active-high reset). One clock; reset is synchronous and active-high.
REQ-002 ID_to_EX_bus input 174; packed MSB->LSB as {valid, pc[31:0], IR[31:0], alu_op[3:0], src1[31:0], src2[31:0], inst_ld_w, mem_we, res_from_mem, gr_we, rkd_value[31:0], rf_waddr[4:0]}.
REQ-003 EX_allowin output 1; high = the bus presented this cycle is consumed at the next clk edge.
REQ-004 EX_to_MEM_bus output reg 138; packed MSB->LSB as {valid, pc, IR, inst_ld_w, mem_we, res_from_mem, gr_we, rkd_value, rf_waddr, alu_result}.

Function
REQ-005 alu_op encoding: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 or, 6 xor, 7 nor, 8 sll, 9 srl, 10 sra, 11 lui (result=src2), 12 mul (low 32 bits), 13 div.w, 14 mod.w, 15 divu.w.
REQ-006 Shift ops use src2[4:0] as the amount; add/sub wrap modulo 2^32; slt signed, sltu unsigned, result 0 or 1.
REQ-007 Ops 0-12: single-cycle; the result is computed combinationally and EX_to_MEM_bus is loaded at the next edge, with every field except alu_result copied from the input.
REQ-008 Divider FSM states IDLE, BUSY, DONE; 5-bit iteration counter cnt.
REQ-009 IDLE, input valid with op 13/14/15: EX_allowin=0; at the edge, capture operand magnitudes and signs, cnt<=0, go BUSY, load a bubble (valid=0) into EX_to_MEM_bus.
REQ-010 BUSY: one restoring radix-2 iteration per edge; cnt increments; at the edge where cnt==31, go DONE; EX_allowin=0; a bubble is loaded each edge.
REQ-011 DONE: EX_allowin=1; at the edge, load EX_to_MEM_bus with valid=1 and the result, then return to IDLE.
REQ-012 Divide latency: the result reaches EX_to_MEM_bus 34 edges after the bus is first presented; upstream holds ID_to_EX_bus stable while EX_allowin=0.
REQ-013 Signed div: quotient sign = sign(src1) XOR sign(src2); remainder sign = sign(src1).
REQ-014 Division by zero: quotient 0xFFFFFFFF; remainder = src1.
REQ-015 Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-016 Input valid=0: EX_allowin=1 and a bubble is loaded; the FSM stays in IDLE.
REQ-017 The loaded valid bit is gated with ~rst.

Reset
REQ-018 When rst=1 at an edge: EX_to_MEM_bus <= 0, state <= IDLE, cnt <= 0.
REQ-019 Reset during BUSY or DONE aborts the division; no result is ever emitted for the aborted instruction.
REQ-020 In the cycle following reset release, EX_allowin reflects the IDLE rules.

Configuration
REQ-021 Macro EX_DIV_EN defined: the divider FSM and ops 13-15 are implemented as in REQ-008 to REQ-015.
REQ-022 Macro EX_DIV_EN undefined: no FSM or counter is built; ops 13-15 complete in a single cycle with alu_result=0; EX_allowin is tied to 1.

Verification
REQ-023 add src1=0x7FFFFFFF, src2=1 -> next edge: bus valid=1, alu_result=0x80000000, pc and IR equal to the input values.
REQ-024 sra src1=0x80000000, src2=0x21 -> alu_result=0xC0000000; sltu src1=1, src2=0xFFFFFFFF -> alu_result=1.
REQ-025 div.w src1=-7 (0xFFFFFFF9), src2=2 -> EX_allowin=0 for 33 cycles, 33 bubbles, then valid=1 with alu_result=0xFFFFFFFD; mod.w on the same operands -> alu_result=0xFFFFFFFF.
REQ-026 divu.w src1=5, src2=0 -> alu_result=0xFFFFFFFF; mod.w src1=5, src2=0 -> alu_result=5; div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-027 Assert rst at the 10th BUSY cycle of a div -> next edge: bus=0 and state IDLE; after release, add 3+4 -> alu_result=7 with no stale divide output.
REQ-028 Build without EX_DIV_EN: div.w 9/3 -> EX_allowin stays 1, next edge alu_result=0.
